reg_mux4_rr_arbiter: RTL and testbench

Four-channel packet arbiter that sits directly upstream of the 4:1 register mux and drives its select bus. Each channel presents valid/data/last; the block grants one channel at a time in round-robin order, holds the grant for a whole packet (until a beat with last), and registers the selected beat into a single valid/ready output stage. A stall watchdog releases a granted channel that stops supplying data mid-packet.

---
 rtl/reg_mux4_rr_arbiter_pkg.sv | 19 +
 rtl/reg_mux4_rr_arbiter_if.sv | 35 +++
 rtl/reg_mux4_rr_arbiter_regmux4.sv | 29 ++
 rtl/reg_mux4_rr_arbiter.sv | 153 +++++++++++++++
 tb/tb_reg_mux4_rr_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_mux4_rr_arbiter_pkg.sv
// Shared types and constants for the four-channel round-robin packet arbiter.
// Holds the arbiter state encoding, channel count, select width and the
// channel index constants used by the data mux and the arbiter.
package reg_mux4_rr_arbiter_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arbState_t;

  localparam logic [SEL_W-1:0] CH_A = 2'd0;
  localparam logic [SEL_W-1:0] CH_B = 2'd1;
  localparam logic [SEL_W-1:0] CH_C = 2'd2;
  localparam logic [SEL_W-1:0] CH_D = 2'd3;

endpackage

// File: rtl/reg_mux4_rr_arbiter_if.sv
// Channel and output-stage bundle of the round-robin packet arbiter.
// Upstream side : InValid/InLast/InputA..InputD in, InReady out (per channel).
// Downstream    : Select/Output/OutValid/OutLast/OutAbort out, OutReady in.
// master = arbiter side, slave = surrounding sources/sink.
interface reg_mux4_rr_arbiter_if #(
  parameter int unsigned INPUT_BIT_WIDTH = 8,
  parameter int unsigned BUS_WIDTH       = 2
) ();
  import reg_mux4_rr_arbiter_pkg::*;

  logic [NUM_CH-1:0]          InValid;
  logic [NUM_CH-1:0]          InLast;
  logic [INPUT_BIT_WIDTH-1:0] InputA;
  logic [INPUT_BIT_WIDTH-1:0] InputB;
  logic [INPUT_BIT_WIDTH-1:0] InputC;
  logic [INPUT_BIT_WIDTH-1:0] InputD;
  logic [NUM_CH-1:0]          InReady;
  logic [BUS_WIDTH-1:0]       Select;
  logic [INPUT_BIT_WIDTH-1:0] Output;
  logic                       OutValid;
  logic                       OutLast;
  logic                       OutReady;
  logic                       OutAbort;

  modport master (
    input  InValid, InLast, InputA, InputB, InputC, InputD, OutReady,
    output InReady, Select, Output, OutValid, OutLast, OutAbort
  );

  modport slave (
    output InValid, InLast, InputA, InputB, InputC, InputD, OutReady,
    input  InReady, Select, Output, OutValid, OutLast, OutAbort
  );

endinterface

// File: rtl/reg_mux4_rr_arbiter_regmux4.sv
// RegMux4: 4:1 data selector driven by the arbiter's Select bus.
// Ports: Select (channel index), InputA..InputD (channel data),
//        muxOut_c (combinational selected data).
module RegMux4
  import reg_mux4_rr_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [SEL_W-1:0] Select,
  input  logic [WIDTH-1:0] InputA,
  input  logic [WIDTH-1:0] InputB,
  input  logic [WIDTH-1:0] InputC,
  input  logic [WIDTH-1:0] InputD,
  output logic [WIDTH-1:0] muxOut_c
);

  // Plain select; Select only moves at grant time so the output is stable per packet.
  always_comb begin
    muxOut_c = InputA;
    case (Select)
      CH_A:    muxOut_c = InputA;
      CH_B:    muxOut_c = InputB;
      CH_C:    muxOut_c = InputC;
      CH_D:    muxOut_c = InputD;
      default: muxOut_c = InputA;
    endcase
  end

endmodule

// File: rtl/reg_mux4_rr_arbiter.sv
// reg_mux4_rr_arbiter: four-channel round-robin packet arbiter feeding a
// single registered valid/ready output stage. A channel keeps the grant for a
// whole packet (through the beat with last). A stall watchdog drops a granted
// channel that stops presenting data and pulses OutAbort.
// Ports: Clock, ResetN (async, active low), bus (arbiter side of
//        reg_mux4_rr_arbiter_if: per-channel valid/last/data/ready,
//        Select, Output, OutValid, OutLast, OutReady, OutAbort).
module reg_mux4_rr_arbiter
  import reg_mux4_rr_arbiter_pkg::*;
#(
  parameter int unsigned INPUT_BIT_WIDTH = 8,
  parameter int unsigned BUS_WIDTH       = 2,
  parameter int unsigned STALL_LIMIT     = 16
) (
  input logic                   Clock,
  input logic                   ResetN,
  reg_mux4_rr_arbiter_if.master bus
);

  localparam int unsigned STALL_W = (STALL_LIMIT == 0) ? 1 : $clog2(STALL_LIMIT + 1);
  localparam int unsigned STALL_LAST_I = (STALL_LIMIT == 0) ? 0 : STALL_LIMIT - 1;
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_LAST_I);
  localparam logic WD_EN = (STALL_LIMIT != 0);

  arbState_t                  state, stateNext;
  logic [BUS_WIDTH-1:0]       pointer, pointerNext;
  logic [BUS_WIDTH-1:0]       selectNext;
  logic [STALL_W-1:0]         stallCnt, stallCntNext;
  logic [INPUT_BIT_WIDTH-1:0] outputNext;
  logic                       outValidNext;
  logic                       outLastNext;
  logic                       outAbortNext;

  logic [INPUT_BIT_WIDTH-1:0] muxData_c;
  logic [BUS_WIDTH-1:0]       winner_c;
  logic [BUS_WIDTH-1:0]       scanIdx_c;
  logic                       anyReq_c;
  logic                       canLoad_c;
  logic                       transfer_c;
  logic                       stall_c;
  logic                       abort_c;

  RegMux4 #(
    .WIDTH (INPUT_BIT_WIDTH)
  ) uRegMux4 (
    .Select   (bus.Select),
    .InputA   (bus.InputA),
    .InputB   (bus.InputB),
    .InputC   (bus.InputC),
    .InputD   (bus.InputD),
    .muxOut_c (muxData_c)
  );

  // Round-robin scan: first requesting channel starting at pointer, wrapping mod 4.
  always_comb begin
    winner_c  = pointer;
    scanIdx_c = pointer;
    anyReq_c  = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      scanIdx_c = pointer + BUS_WIDTH'(i);
      if (!anyReq_c && bus.InValid[scanIdx_c]) begin
        winner_c = scanIdx_c;
        anyReq_c = 1'b1;
      end
    end
  end

  // Handshake terms; InReady depends only on state, Select and the output stage.
  always_comb begin
    canLoad_c   = ~bus.OutValid | bus.OutReady;
    transfer_c  = (state == LOCKED) & bus.InValid[bus.Select] & canLoad_c;
    stall_c     = (state == LOCKED) & ~bus.InValid[bus.Select];
    abort_c     = WD_EN & stall_c & (stallCnt == STALL_LAST);
    bus.InReady = '0;
    if (state == LOCKED) begin
      bus.InReady[bus.Select] = canLoad_c;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    stateNext    = state;
    pointerNext  = pointer;
    selectNext   = bus.Select;
    stallCntNext = stallCnt;
    outputNext   = bus.Output;
    outValidNext = bus.OutValid;
    outLastNext  = bus.OutLast;
    outAbortNext = 1'b0;

    // Drain; overridden below when a new beat is loaded in the same cycle.
    if (bus.OutValid && bus.OutReady) begin
      outValidNext = 1'b0;
    end

    case (state)
      IDLE: begin
        if (anyReq_c) begin
          selectNext   = winner_c;
          stateNext    = LOCKED;
          stallCntNext = '0;
        end
      end
      LOCKED: begin
        if (transfer_c) begin
          outputNext   = muxData_c;
          outLastNext  = bus.InLast[bus.Select];
          outValidNext = 1'b1;
          stallCntNext = '0;
          if (bus.InLast[bus.Select]) begin
            stateNext   = IDLE;
            pointerNext = bus.Select + BUS_WIDTH'(1);
          end
        end else if (abort_c) begin
          // Forced release: the partial packet is left unterminated downstream.
          stateNext    = IDLE;
          pointerNext  = bus.Select + BUS_WIDTH'(1);
          outAbortNext = 1'b1;
          stallCntNext = '0;
        end else if (stall_c && WD_EN) begin
          stallCntNext = stallCnt + STALL_W'(1);
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state        <= IDLE;
      pointer      <= '0;
      stallCnt     <= '0;
      bus.Select   <= '0;
      bus.Output   <= '0;
      bus.OutValid <= 1'b0;
      bus.OutLast  <= 1'b0;
      bus.OutAbort <= 1'b0;
    end else begin
      state        <= stateNext;
      pointer      <= pointerNext;
      stallCnt     <= stallCntNext;
      bus.Select   <= selectNext;
      bus.Output   <= outputNext;
      bus.OutValid <= outValidNext;
      bus.OutLast  <= outLastNext;
      bus.OutAbort <= outAbortNext;
    end
  end

endmodule

// File: tb/tb_reg_mux4_rr_arbiter.sv
// Self-checking bench for reg_mux4_rr_arbiter: directed scenarios plus
// randomized packet traffic compared against a transaction-level
// round-robin model (expected beat stream and grant order).
module tb_reg_mux4_rr_arbiter;

  logic Clock;
  logic ResetN;

  reg_mux4_rr_arbiter_if #(.INPUT_BIT_WIDTH(8), .BUS_WIDTH(2)) bus ();

  reg_mux4_rr_arbiter #(
    .INPUT_BIT_WIDTH (8),
    .BUS_WIDTH       (2),
    .STALL_LIMIT     (4)
  ) dut (
    .Clock  (Clock),
    .ResetN (ResetN),
    .bus    (bus.master)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  int vectors = 0;
  int miscompares = 0;

  // Source queues and observation records.
  logic [7:0] srcData[4][$];
  bit         srcLast[4][$];
  beat_t      obsQ[$];
  int         grantQ[$];
  int         grantCyc[$];
  beat_t      expBeats[$];
  int         expGrants[$];
  int         modelPtr;
  int         abortSeen;
  int         oneHotBad;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_ch(input int ch, input bit v, input logic [7:0] d, input bit l);
    bus.InValid[ch] = v;
    bus.InLast[ch]  = l;
    case (ch)
      0: bus.InputA = d;
      1: bus.InputB = d;
      2: bus.InputC = d;
      default: bus.InputD = d;
    endcase
  endtask

  task automatic clear_inputs();
    bus.InValid  = '0;
    bus.InLast   = '0;
    bus.InputA   = '0;
    bus.InputB   = '0;
    bus.InputC   = '0;
    bus.InputD   = '0;
    bus.OutReady = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    ResetN = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    ResetN   = 1'b1;
    modelPtr = 0;
  endtask

  task automatic load_pkt(input int ch, input int len);
    for (int b = 0; b < len; b++) begin
      srcData[ch].push_back(8'($urandom_range(255)));
      srcLast[ch].push_back(b == len - 1);
    end
  endtask

  // Model: whole packets in round-robin order over channels with pending packets.
  function automatic void build_expected();
    logic [7:0] qd[4][$];
    bit         ql[4][$];
    int         p, ch;
    bit         found, last;
    beat_t      b;
    expBeats.delete();
    expGrants.delete();
    for (int c = 0; c < 4; c++) begin
      qd[c] = srcData[c];
      ql[c] = srcLast[c];
    end
    p  = modelPtr;
    ch = 0;
    for (int n = 0; n < 64; n++) begin
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (!found && qd[(p + k) % 4].size() > 0) begin
          ch    = (p + k) % 4;
          found = 1'b1;
        end
      end
      if (!found) break;
      expGrants.push_back(ch);
      last = 1'b0;
      while (!last && qd[ch].size() > 0) begin
        b.d  = qd[ch].pop_front();
        b.l  = ql[ch].pop_front();
        last = b.l;
        expBeats.push_back(b);
      end
      p = (ch + 1) % 4;
    end
    modelPtr = p;
  endfunction

  // Drives sources from srcData/srcLast with optional mid-packet gaps and
  // random OutReady; records consumed beats and packet grant order.
  task automatic run_traffic(input int maxCycles, input int readyPct, input int maxGap,
                             output bit timedOut);
    int gap[4];
    bit midPkt[4];
    bit acc[4];
    beat_t b;
    obsQ.delete();
    grantQ.delete();
    grantCyc.delete();
    abortSeen = 0;
    oneHotBad = 0;
    timedOut  = 1'b1;
    for (int ch = 0; ch < 4; ch++) begin
      gap[ch]    = 0;
      midPkt[ch] = 1'b0;
    end
    for (int c = 0; c < maxCycles; c++) begin
      for (int ch = 0; ch < 4; ch++) begin
        if (srcData[ch].size() > 0 && gap[ch] == 0)
          set_ch(ch, 1'b1, srcData[ch][0], srcLast[ch][0]);
        else
          set_ch(ch, 1'b0, 8'h00, 1'b0);
      end
      bus.OutReady = ($urandom_range(99) < readyPct);
      #1;
      if ((bus.InReady & (bus.InReady - 4'd1)) != 4'd0) oneHotBad++;
      if (bus.OutAbort) abortSeen++;
      if (bus.OutValid && bus.OutReady) begin
        b.d = bus.Output;
        b.l = bus.OutLast;
        obsQ.push_back(b);
      end
      for (int ch = 0; ch < 4; ch++) acc[ch] = bus.InValid[ch] & bus.InReady[ch];
      step();
      for (int ch = 0; ch < 4; ch++) begin
        if (acc[ch]) begin
          if (!midPkt[ch]) begin
            grantQ.push_back(ch);
            grantCyc.push_back(c);
          end
          void'(srcData[ch].pop_front());
          midPkt[ch] = !srcLast[ch].pop_front();
          gap[ch]    = midPkt[ch] ? $urandom_range(maxGap, 0) : 0;
        end else if (gap[ch] > 0) begin
          gap[ch]--;
        end
      end
      if (srcData[0].size() == 0 && srcData[1].size() == 0 && srcData[2].size() == 0 &&
          srcData[3].size() == 0 && !bus.OutValid) begin
        timedOut = 1'b0;
        break;
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    ResetN = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    vectors++; if (bus.Select !== 2'd0) begin miscompares++; $display("FAIL reset_select: got %0h want 0", bus.Select); end
    vectors++; if (bus.Output !== 8'h00) begin miscompares++; $display("FAIL reset_output: got %0h want 0", bus.Output); end
    vectors++; if (bus.OutValid !== 1'b0) begin miscompares++; $display("FAIL reset_outvalid: got %0b want 0", bus.OutValid); end
    vectors++; if (bus.OutLast !== 1'b0) begin miscompares++; $display("FAIL reset_outlast: got %0b want 0", bus.OutLast); end
    vectors++; if (bus.OutAbort !== 1'b0) begin miscompares++; $display("FAIL reset_outabort: got %0b want 0", bus.OutAbort); end
    vectors++; if (bus.InReady !== 4'b0000) begin miscompares++; $display("FAIL reset_inready: got %b want 0000", bus.InReady); end
    ResetN   = 1'b1;
    modelPtr = 0;
  endtask

  task automatic test_single_packet();
    int want[4] = '{2, 3, 0, 1};
    bit to;
    do_reset();
    bus.OutReady = 1'b1;
    set_ch(1, 1'b1, 8'h11, 1'b0);
    step();
    vectors++; if (bus.Select !== 2'd1) begin miscompares++; $display("FAIL single_select: got %0d want 1", bus.Select); end
    vectors++; if (bus.InReady !== 4'b0010) begin miscompares++; $display("FAIL single_inready: got %b want 0010", bus.InReady); end
    vectors++; if (bus.OutValid !== 1'b0) begin miscompares++; $display("FAIL single_outvalid_n1: got %0b want 0", bus.OutValid); end
    step();
    set_ch(1, 1'b1, 8'h22, 1'b0);
    vectors++; if (bus.OutValid !== 1'b1 || bus.Output !== 8'h11 || bus.OutLast !== 1'b0) begin miscompares++; $display("FAIL single_beat0: got v%0b %0h l%0b want v1 11 l0", bus.OutValid, bus.Output, bus.OutLast); end
    step();
    set_ch(1, 1'b1, 8'h33, 1'b1);
    vectors++; if (bus.Output !== 8'h22 || bus.OutLast !== 1'b0) begin miscompares++; $display("FAIL single_beat1: got %0h l%0b want 22 l0", bus.Output, bus.OutLast); end
    step();
    set_ch(1, 1'b0, 8'h00, 1'b0);
    #1;
    vectors++; if (bus.Output !== 8'h33 || bus.OutLast !== 1'b1 || bus.OutValid !== 1'b1) begin miscompares++; $display("FAIL single_beat2: got v%0b %0h l%0b want v1 33 l1", bus.OutValid, bus.Output, bus.OutLast); end
    vectors++; if (bus.InReady !== 4'b0000) begin miscompares++; $display("FAIL single_idle_inready: got %b want 0000", bus.InReady); end
    step();
    vectors++; if (bus.OutValid !== 1'b0 || bus.Output !== 8'h33) begin miscompares++; $display("FAIL single_drain: got v%0b %0h want v0 33", bus.OutValid, bus.Output); end
    // Pointer now 2: all four requesting must be served 2,3,0,1.
    for (int ch = 0; ch < 4; ch++) load_pkt(ch, 1);
    run_traffic(100, 100, 0, to);
    vectors++; if (to || grantQ.size() != 4) begin miscompares++; $display("FAIL single_rr_count: got %0d grants timeout %0b want 4", grantQ.size(), to); end
    for (int i = 0; i < 4 && i < grantQ.size(); i++) begin
      vectors++; if (grantQ[i] != want[i]) begin miscompares++; $display("FAIL single_rr_order%0d: got %0d want %0d", i, grantQ[i], want[i]); end
    end
  endtask

  task automatic test_fairness();
    bit to;
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int ch = 0; ch < 4; ch++) load_pkt(ch, 1);
    build_expected();
    run_traffic(200, 100, 0, to);
    vectors++; if (to || grantQ.size() != expGrants.size()) begin miscompares++; $display("FAIL fair_count: got %0d want %0d timeout %0b", grantQ.size(), expGrants.size(), to); end
    for (int i = 0; i < grantQ.size() && i < expGrants.size(); i++) begin
      vectors++; if (grantQ[i] != expGrants[i]) begin miscompares++; $display("FAIL fair_order%0d: got %0d want %0d", i, grantQ[i], expGrants[i]); end
    end
    for (int i = 1; i < grantCyc.size(); i++) begin
      vectors++; if (grantCyc[i] - grantCyc[i-1] != 2) begin miscompares++; $display("FAIL fair_bubble%0d: got spacing %0d want 2", i, grantCyc[i] - grantCyc[i-1]); end
    end
  endtask

  task automatic test_backpressure();
    int nextBeat = 0;
    logic [7:0] got[$];
    logic [7:0] held = 8'h00;
    bit acc;
    do_reset();
    for (int c = 0; c < 40 && (nextBeat < 8 || bus.OutValid); c++) begin
      if (nextBeat < 8) set_ch(3, 1'b1, 8'(8'hA0 + nextBeat), nextBeat == 7);
      else set_ch(3, 1'b0, 8'h00, 1'b0);
      bus.OutReady = !(c >= 4 && c < 9);
      #1;
      if (c == 4) held = bus.Output;
      if (c >= 4 && c < 9) begin
        vectors++; if (bus.OutValid !== 1'b1) begin miscompares++; $display("FAIL bp_outvalid_c%0d: got %0b want 1", c, bus.OutValid); end
        vectors++; if (bus.InReady !== 4'b0000) begin miscompares++; $display("FAIL bp_inready_c%0d: got %b want 0000", c, bus.InReady); end
        if (c > 4) begin
          vectors++; if (bus.Output !== held) begin miscompares++; $display("FAIL bp_stable_c%0d: got %0h want %0h", c, bus.Output, held); end
        end
      end
      acc = bus.InValid[3] & bus.InReady[3];
      if (bus.OutValid && bus.OutReady) got.push_back(bus.Output);
      step();
      if (acc) nextBeat++;
    end
    clear_inputs();
    vectors++; if (got.size() != 8) begin miscompares++; $display("FAIL bp_count: got %0d beats want 8", got.size()); end
    for (int i = 0; i < got.size() && i < 8; i++) begin
      vectors++; if (got[i] !== 8'(8'hA0 + i)) begin miscompares++; $display("FAIL bp_beat%0d: got %0h want %0h", i, got[i], 8'(8'hA0 + i)); end
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    bus.OutReady = 1'b1;
    set_ch(2, 1'b1, 8'h5A, 1'b0);
    step();
    vectors++; if (bus.Select !== 2'd2 || bus.InReady !== 4'b0100) begin miscompares++; $display("FAIL wd_grant: got sel %0d rdy %b want 2 0100", bus.Select, bus.InReady); end
    step();
    set_ch(2, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 4; k++) begin
      vectors++; if (bus.OutAbort !== 1'b0) begin miscompares++; $display("FAIL wd_early_abort%0d: got %0b want 0", k, bus.OutAbort); end
      step();
    end
    vectors++; if (bus.OutAbort !== 1'b1) begin miscompares++; $display("FAIL wd_abort: got %0b want 1", bus.OutAbort); end
    vectors++; if (bus.OutLast !== 1'b0 || bus.Output !== 8'h5A) begin miscompares++; $display("FAIL wd_no_last: got %0h l%0b want 5a l0", bus.Output, bus.OutLast); end
    for (int ch = 0; ch < 4; ch++) set_ch(ch, 1'b1, 8'(8'hC0 + ch), 1'b1);
    step();
    vectors++; if (bus.OutAbort !== 1'b0) begin miscompares++; $display("FAIL wd_abort_pulse: got %0b want 0", bus.OutAbort); end
    vectors++; if (bus.Select !== 2'd3 || bus.InReady !== 4'b1000) begin miscompares++; $display("FAIL wd_next_grant: got sel %0d rdy %b want 3 1000", bus.Select, bus.InReady); end
    for (int ch = 0; ch < 3; ch++) set_ch(ch, 1'b0, 8'h00, 1'b0);
    step();
    set_ch(3, 1'b0, 8'h00, 1'b0);
    vectors++; if (bus.Output !== 8'hC3 || bus.OutLast !== 1'b1) begin miscompares++; $display("FAIL wd_after_beat: got %0h l%0b want c3 l1", bus.Output, bus.OutLast); end
    repeat (3) step();
    clear_inputs();
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    bus.OutReady = 1'b1;
    set_ch(3, 1'b1, 8'h31, 1'b0);
    step();
    step();
    set_ch(3, 1'b1, 8'h32, 1'b0);
    vectors++; if (bus.Select !== 2'd3 || bus.OutValid !== 1'b1) begin miscompares++; $display("FAIL rmp_pre: got sel %0d v%0b want 3 v1", bus.Select, bus.OutValid); end
    #2;
    ResetN = 1'b0;
    #1;
    vectors++; if (bus.Select !== 2'd0) begin miscompares++; $display("FAIL rmp_select: got %0d want 0", bus.Select); end
    vectors++; if (bus.OutValid !== 1'b0) begin miscompares++; $display("FAIL rmp_outvalid: got %0b want 0", bus.OutValid); end
    vectors++; if (bus.InReady !== 4'b0000) begin miscompares++; $display("FAIL rmp_inready: got %b want 0000", bus.InReady); end
    step();
    ResetN   = 1'b1;
    modelPtr = 0;
    set_ch(0, 1'b1, 8'h01, 1'b1);
    step();
    vectors++; if (bus.Select !== 2'd0 || bus.InReady !== 4'b0001) begin miscompares++; $display("FAIL rmp_regrant: got sel %0d rdy %b want 0 0001", bus.Select, bus.InReady); end
    clear_inputs();
    repeat (3) step();
  endtask

  task automatic test_random();
    bit to;
    do_reset();
    for (int r = 0; r < 4; r++) begin
      for (int ch = 0; ch < 4; ch++)
        for (int p = $urandom_range(3, 0); p > 0; p--) load_pkt(ch, $urandom_range(5, 1));
      build_expected();
      run_traffic(3000, 70, 2, to);
      vectors++; if (to) begin miscompares++; $display("FAIL rand%0d_timeout: got timeout 1 want 0", r); end
      vectors++; if (obsQ.size() != expBeats.size()) begin miscompares++; $display("FAIL rand%0d_beats: got %0d want %0d", r, obsQ.size(), expBeats.size()); end
      for (int i = 0; i < obsQ.size() && i < expBeats.size(); i++) begin
        vectors++; if (obsQ[i] !== expBeats[i]) begin miscompares++; $display("FAIL rand%0d_beat%0d: got %0h/%0b want %0h/%0b", r, i, obsQ[i].d, obsQ[i].l, expBeats[i].d, expBeats[i].l); end
      end
      vectors++; if (grantQ.size() != expGrants.size()) begin miscompares++; $display("FAIL rand%0d_grants: got %0d want %0d", r, grantQ.size(), expGrants.size()); end
      for (int i = 0; i < grantQ.size() && i < expGrants.size(); i++) begin
        vectors++; if (grantQ[i] != expGrants[i]) begin miscompares++; $display("FAIL rand%0d_grant%0d: got %0d want %0d", r, i, grantQ[i], expGrants[i]); end
      end
      vectors++; if (abortSeen != 0) begin miscompares++; $display("FAIL rand%0d_abort: got %0d want 0", r, abortSeen); end
      vectors++; if (oneHotBad != 0) begin miscompares++; $display("FAIL rand%0d_onehot: got %0d want 0", r, oneHotBad); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end

  initial begin
    ResetN = 1'b0;
    clear_inputs();
    test_reset();
    test_single_packet();
    test_fairness();
    test_backpressure();
    test_watchdog();
    test_reset_mid_packet();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
